// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared state type and arithmetic helpers for the iterative NTT core
package ntt_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

  // Modular butterfly for operands up to 31 bits; returns {hi, lo} in 32-bit halves.
  function automatic logic [63:0] mod_bfly(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] w, input logic [31:0] q);
    logic [63:0] s_hi;
    logic [63:0] s_lo;
    logic [63:0] r_hi;
    logic [63:0] r_lo;
    s_hi = {32'd0, a} + {32'd0, b} * {32'd0, w};
    s_lo = {32'd0, a} + {32'd0, b} * {32'd0, q - w};
    if (q == 32'd0) begin
      r_hi = 64'd0;
      r_lo = 64'd0;
    end else begin
      r_hi = s_hi % {32'd0, q};
      r_lo = s_lo % {32'd0, q};
    end
    return {r_hi[31:0], r_lo[31:0]};
  endfunction

  function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) begin
      r = (r << 1) | ((v >> i) & 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_bfly.sv
// rtl/ntt_bfly.sv - combinational modular butterfly: hi = a + b*w, lo = a + b*(q-w), both mod q
module ntt_bfly
  import ntt_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] w,
  input  logic [W-1:0] q,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  logic [63:0] res;

  assign res = mod_bfly(32'(a), 32'(b), 32'(w), 32'(q));
  assign hi  = W'(res >> 32);
  assign lo  = W'(res);

endmodule

// File: rtl/ntt_iter_core.sv
// rtl/ntt_iter_core.sv - in-place radix-2 DIT NTT, one shared butterfly per cycle across all stages
module ntt_iter_core
  import ntt_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 8,
  localparam int LOGN = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    cfg_mod,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic [LOGN-2:0] tw_idx,
  input  logic [W-1:0]    tw_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            busy,
  output logic            done
);

  localparam int SW = $clog2(LOGN);
  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);
  localparam logic [SW-1:0]   LAST_STG = SW'(LOGN - 1);

  state_t state, state_next;

  logic [W-1:0]    mem [N];
  logic [W-1:0]    q_reg;
  logic [LOGN-1:0] cnt;
  logic [LOGN-1:0] ocnt;
  logic [LOGN-2:0] pcnt;
  logic [SW-1:0]   stg;
  logic            out_vld;

  logic [LOGN-1:0] p_ext, bit_h, low_mask, a_addr, b_addr, tw_full;
  logic [W-1:0]    bf_hi, bf_lo;
  logic            accept, hs, last_pair, last_out;

  // Pair p of stage s: a_addr is p with a zero bit inserted at position s, b_addr sets that bit.
  always_comb begin
    p_ext    = {1'b0, pcnt};
    bit_h    = LOGN'(1) << stg;
    low_mask = bit_h - LOGN'(1);
    a_addr   = ((p_ext & ~low_mask) << 1) | (p_ext & low_mask);
    b_addr   = a_addr | bit_h;
    tw_full  = (p_ext & low_mask) << (LAST_STG - stg);
  end

  assign accept    = (state == LOAD) && in_valid;
  assign hs        = out_vld && out_ready;
  assign last_pair = (pcnt == '1) && (stg == LAST_STG);
  assign last_out  = hs && (ocnt == LAST_IDX);

  ntt_bfly #(.W(W)) u_bfly (
    .a  (mem[a_addr]),
    .b  (mem[b_addr]),
    .w  (tw_data),
    .q  (q_reg),
    .hi (bf_hi),
    .lo (bf_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    tw_idx     = '0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (accept && (cnt == LAST_IDX)) state_next = COMPUTE;
      end
      COMPUTE: begin
        busy   = 1'b1;
        tw_idx = (LOGN-1)'(tw_full);
        if (last_pair) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        done = last_out;
        if (last_out) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  assign out_valid = out_vld;
  assign out_data  = mem[ocnt];

  // out_valid is registered, so the first output beat comes one cycle after COMPUTE ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ocnt    <= '0;
      pcnt    <= '0;
      stg     <= '0;
      q_reg   <= '0;
      out_vld <= 1'b0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      out_vld <= (state == DRAIN) && (state_next == DRAIN);
      case (state)
        LOAD: begin
          if (accept) begin
            mem[cnt] <= in_data;
            cnt      <= cnt + 1'b1;
            if (cnt == '0) q_reg <= cfg_mod;
          end
        end
        COMPUTE: begin
          mem[a_addr] <= bf_hi;
          mem[b_addr] <= bf_lo;
          pcnt        <= pcnt + 1'b1;
          if (pcnt == '1) stg <= last_pair ? '0 : stg + 1'b1;
        end
        DRAIN: begin
          if (hs) ocnt <= ocnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_iter_core.sv
// tb/tb_ntt_iter_core.sv - randomized self-checking bench for ntt_iter_core against a DFT/WHT reference
module tb_ntt_iter_core;
  import ntt_pkg::*;

  localparam int W = 8;
  localparam int N = 8;
  localparam int LOGN = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    cfg_mod;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic [LOGN-2:0] tw_idx;
  logic [W-1:0]    tw_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            busy;
  logic            done;

  logic [7:0] tw_tab [4];
  int errors = 0;
  int checks = 0;
  int din  [N];
  int expv [N];

  always #5 clk = ~clk;

  assign tw_data = tw_tab[tw_idx];

  ntt_iter_core #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_mod   (cfg_mod),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .tw_idx    (tw_idx),
    .tw_data   (tw_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  // mode 0: din holds x in bit-reversed order, X[k] = sum x[n]*2^(nk) mod q (omega = 2).
  // mode 1: all twiddles 1, giving a Walsh-Hadamard transform of the beat sequence.
  function automatic int ref_point(input int k, input int q, input int mode);
    longint acc;
    acc = 0;
    for (int n = 0; n < N; n++) begin
      if (mode == 0)
        acc += longint'(din[bitrev(unsigned'(n), 3)]) * longint'((1 << ((n * k) % N)) % q);
      else if (($countones(n & k) % 2) == 1)
        acc -= longint'(din[n]);
      else
        acc += longint'(din[n]);
    end
    return int'(((acc % q) + q) % q);
  endfunction

  task automatic send_frame(input int q, input bit chg, input string tag);
    int guard;
    cfg_mod = 8'(q);
    for (int m = 0; m < N; m++) begin
      in_valid = 1'b1;
      in_data  = 8'(din[m]);
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      checks++;
      if (guard >= 50) begin
        errors++;
        $display("FAIL %s load_timeout beat %0d: in_ready=%0d required 1", tag, m, in_ready);
      end
      @(posedge clk); #1;
      if (chg && m == 3) cfg_mod = 8'd13;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int q, input int mode, input int duty, input bit chg,
                           input bit junk, input bit chk_tw, input string tag);
    int lat, beats, dcnt, guard, s, h, expt;
    bit stalled;
    logic [W-1:0] held;
    for (int k = 0; k < N; k++) expv[k] = ref_point(k, q, mode);
    send_frame(q, chg, tag);
    out_ready = 1'b0;
    lat = 0;
    held = '0;
    while (!out_valid && lat < 100) begin
      if (junk) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      if (chk_tw && lat < 12) begin
        s = lat / 4;
        h = 1 << s;
        expt = ((lat % 4) % h) * (N / (2 * h));
        checks++;
        if (tw_idx !== 2'(expt)) begin
          errors++;
          $display("FAIL %s tw_idx cycle %0d: got %0d required %0d", tag, lat, tw_idx, expt);
        end
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s compute_flags cycle %0d: in_ready=%0d busy=%0d required 0/1",
                 tag, lat, in_ready, busy);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL %s latency: got %0d edges required 13", tag, lat);
    end
    beats = 0; dcnt = 0; guard = 0; stalled = 1'b0;
    while (beats < N && guard < 400) begin
      out_ready = ($urandom_range(0, 99) < duty);
      #1;
      if (out_valid) begin
        if (stalled) begin
          checks++;
          if (out_data !== held) begin
            errors++;
            $display("FAIL %s hold beat %0d: got %0d required %0d", tag, beats, out_data, held);
          end
        end
        if (out_ready) begin
          checks++;
          if (out_data !== 8'(expv[beats])) begin
            errors++;
            $display("FAIL %s data[%0d]: got %0d required %0d", tag, beats, out_data, expv[beats]);
          end
          checks++;
          if (done !== (beats == N - 1)) begin
            errors++;
            $display("FAIL %s done at beat %0d: got %0d required %0d", tag, beats, done, beats == N - 1);
          end
          beats++;
          stalled = 1'b0;
        end else begin
          held = out_data;
          stalled = 1'b1;
        end
      end else begin
        checks++;
        errors++;
        $display("FAIL %s out_valid dropped at beat %0d: got 0 required 1", tag, beats);
      end
      if (done === 1'b1) dcnt++;
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b0;
    checks++;
    if (beats != N) begin
      errors++;
      $display("FAIL %s beat_count: got %0d required %0d", tag, beats, N);
    end
    checks++;
    if (dcnt != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d required 1", tag, dcnt);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s post_frame: in_ready=%0d out_valid=%0d busy=%0d done=%0d required 1/0/0/0",
               tag, in_ready, out_valid, busy, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        tw_idx !== 2'd0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%0d out_valid=%0d busy=%0d done=%0d tw_idx=%0d out_data=%0d required 1/0/0/0/0/0",
               in_ready, out_valid, busy, done, tw_idx, out_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0d busy=%0d required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_impulse();
    for (int i = 0; i < N; i++) din[i] = (i == 0) ? 1 : 0;
    run_frame(17, 0, 100, 1'b0, 1'b0, 1'b1, "impulse");
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < N; i++) din[i] = 1;
    run_frame(17, 0, 100, 1'b0, 1'b1, 1'b0, "all_ones");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 200; f++) begin
      for (int i = 0; i < N; i++) din[i] = $urandom_range(0, 16);
      run_frame(17, 0, 100, 1'b0, (f % 10) == 0, 1'b0, "b2b");
    end
  endtask

  task automatic test_stall();
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) din[i] = $urandom_range(0, 16);
      run_frame(17, 0, 30, 1'b0, 1'b0, 1'b0, "stall");
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) din[i] = $urandom_range(0, 16);
    send_frame(17, 1'b0, "rst_mid");
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || tw_idx !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid async: out_valid=%0d in_ready=%0d busy=%0d tw_idx=%0d required 0/1/0/0",
               out_valid, in_ready, busy, tw_idx);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid no_output: out_valid=%0d required 0", out_valid);
      end
    end
    for (int i = 0; i < N; i++) din[i] = $urandom_range(0, 16);
    run_frame(17, 0, 100, 1'b0, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_cfg_mod();
    for (int i = 0; i < N; i++) din[i] = $urandom_range(0, 12);
    run_frame(17, 0, 100, 1'b1, 1'b0, 1'b0, "cfg_chg17");
    for (int i = 0; i < 4; i++) tw_tab[i] = 8'd1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) din[i] = $urandom_range(0, 12);
      run_frame(13, 1, 100, 1'b0, 1'b0, 1'b0, "cfg_mod13");
    end
    tw_tab[0] = 8'd1; tw_tab[1] = 8'd2; tw_tab[2] = 8'd4; tw_tab[3] = 8'd8;
  endtask

  initial begin
    tw_tab[0] = 8'd1; tw_tab[1] = 8'd2; tw_tab[2] = 8'd4; tw_tab[3] = 8'd8;
    rst_n     = 1'b0;
    cfg_mod   = 8'd17;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_impulse();
    test_all_ones();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_cfg_mod();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
